ysyx_22040127_divider: RTL and testbench

YSYX_22040127_DIVIDER -- requirements
Module: ysyx_22040127_divider

---
 rtl/ysyx_22040127_divider.sv | 179 +++++++++++++++++
 tb/tb_ysyx_22040127_divider.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040127_divider.sv
// ysyx_22040127_divider: iterative radix-2 restoring divider with signed,
// unsigned and 32-bit word modes. One quotient bit per cycle, a single
// sign-fixup cycle, and a held result slot released by out_ready.
module ysyx_22040127_divider #(
    parameter int XLEN     = 64,
    parameter int HAS_WORD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    input  logic            is_word,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            busy
);

    localparam int CW      = $clog2(XLEN) + 1;
    localparam int WW      = (XLEN >= 32) ? 32 : XLEN;
    localparam bit WORD_EN = (HAS_WORD != 0) && (XLEN >= 32);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            word_q, word_d;

    logic            word_in;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val;
    logic            neg_a, neg_b, div0, ovf;
    logic [XLEN:0]   shifted, diff;
    logic            ge;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] y;
        y = x;
        for (int unsigned i = WW; i < XLEN; i++) y[i] = x[WW-1];
        return y;
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] y;
        y = x;
        for (int unsigned i = WW; i < XLEN; i++) y[i] = 1'b0;
        return y;
    endfunction

    assign in_ready  = (state_q == S_IDLE) && !flush && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // Operand conditioning: word extension, magnitudes and bypass detection.
    always_comb begin
        word_in = WORD_EN && is_word;
        a_ext   = dividend;
        b_ext   = divisor;
        if (word_in) begin
            a_ext = is_signed ? sext_w(dividend) : zext_w(dividend);
            b_ext = is_signed ? sext_w(divisor)  : zext_w(divisor);
        end
        neg_a   = is_signed && a_ext[XLEN-1];
        neg_b   = is_signed && b_ext[XLEN-1];
        mag_a   = neg_a ? -a_ext : a_ext;
        mag_b   = neg_b ? -b_ext : b_ext;
        min_val = word_in ? sext_w(XLEN'(1) << (WW - 1)) : (XLEN'(1) << (XLEN - 1));
        div0    = (b_ext == '0);
        ovf     = is_signed && (a_ext == min_val) && (b_ext == '1);
    end

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dsr_q};
        ge      = !diff[XLEN];
    end

    // Next-state and datapath update; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    word_d = word_in;
                    negq_d = neg_a ^ neg_b;
                    negr_d = neg_a;
                    dsr_d  = mag_b;
                    cnt_d  = word_in ? CW'(WW) : CW'(XLEN);
                    if (div0) begin
                        quo_d   = '1;
                        rem_d   = word_in ? sext_w(a_ext) : a_ext;
                        state_d = S_DONE;
                    end else if (ovf) begin
                        quo_d   = a_ext;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        // Word magnitudes are parked at the top so that only
                        // WW iterations are needed to consume them.
                        quo_d   = word_in ? (mag_a << (XLEN - WW)) : mag_a;
                        rem_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                quo_d = {quo_q[XLEN-2:0], ge};
                rem_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                quo_d   = negq_q ? -quo_q : quo_q;
                rem_d   = negr_q ? -rem_q : rem_q;
                if (word_q) begin
                    quo_d = sext_w(quo_d);
                    rem_d = sext_w(rem_d);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22040127_divider.sv
// Scoreboard bench for ysyx_22040127_divider: driver pushes expected results
// from a plain-arithmetic reference model; monitor pops on out_valid.
module tb_ysyx_22040127_divider;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, is_signed, is_word, flush;
    logic            out_valid, out_ready, busy;
    logic [XLEN-1:0] dividend, divisor, quotient, remainder;

    ysyx_22040127_divider #(.XLEN(XLEN), .HAS_WORD(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
        .is_word(is_word), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          acc;
        int          lat;
        int          hold;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // Reference: RISC-V M-extension division semantics in plain arithmetic.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input bit s, input bit w,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output int lat);
        logic [31:0]    ua, ub, q32, r32;
        int signed      sa32, sb32;
        longint signed  sa, sb;
        if (w) begin
            ua = a[31:0];
            ub = b[31:0];
            sa32 = ua;
            sb32 = ub;
            if (ub == 32'd0) begin
                q = '1; r = {{32{ua[31]}}, ua}; lat = 1;
            end else if (s && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
                q = {{32{1'b1}}, ua}; r = '0; lat = 1;
            end else begin
                if (s) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
                else   begin q32 = ua / ub;     r32 = ua % ub;     end
                q = {{32{q32[31]}}, q32};
                r = {{32{r32[31]}}, r32};
                lat = 34;
            end
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a; lat = 1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = '0; lat = 1;
            end else begin
                sa = a; sb = b;
                if (s) begin q = sa / sb; r = sa % sb; end
                else   begin q = a / b;   r = a % b;   end
                lat = 66;
            end
        end
    endfunction

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit s,
                         input bit w, input int hold, input bit push);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL in_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
            return;
        end
        dividend = a; divisor = b; is_signed = s; is_word = w; in_valid = 1'b1;
        if (push) begin
            model(a, b, s, w, e.q, e.r, e.lat);
            e.acc  = cyc;
            e.hold = hold;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        is_signed = 1'($urandom);
        is_word   = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 9))
            0: v = 64'd0;
            1: v = 64'd1;
            2: v = '1;
            3: v = 64'h8000_0000_0000_0000;
            4: v = {$urandom, 32'h8000_0000};
            5: v = 64'($urandom_range(0, 100));
            6: v = -64'($urandom_range(1, 100));
            7: v = {$urandom, $urandom} >> $urandom_range(0, 63);
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Monitor/consumer: checks latency, value and stability while held.
    initial begin
        exp_t e;
        bit   seen;
        int   held;
        seen = 1'b0;
        held = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_ready = 1'b0;
                seen = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                    out_ready = 1'b1;
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen = 1'b1;
                        held = 0;
                        chk("latency", 64'(cyc), 64'(e.acc + e.lat));
                        chk("quotient", quotient, e.q);
                        chk("remainder", remainder, e.r);
                    end else begin
                        chk("quotient_hold", quotient, e.q);
                        chk("remainder_hold", remainder, e.r);
                        chk("in_ready_hold", 64'(in_ready), 64'd0);
                    end
                    if (held >= e.hold) begin
                        out_ready = 1'b1;
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end else begin
                        out_ready = 1'b0;
                        held++;
                    end
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        dividend = '0; divisor = '0; is_signed = 1'b0; is_word = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_quotient", quotient, 64'd0);
        chk("rst_remainder", remainder, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        issue(64'd100, 64'd7, 1'b0, 1'b0, 5, 1'b1);
        issue(-64'd7, 64'd2, 1'b1, 1'b0, 0, 1'b1);
        issue(64'd7, -64'd2, 1'b1, 1'b0, 0, 1'b1);
        issue(64'h0000_0001_8000_0000, '1, 1'b1, 1'b1, 0, 1'b1);
        issue(64'h1234, 64'd0, 1'b0, 1'b0, 0, 1'b1);
        issue(64'd5, 64'd0, 1'b0, 1'b1, 0, 1'b1);
        issue(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1, 1'b1);
        issue(64'hDEAD_BEEF_1234_5678, 64'h0000_0000_0001_0003, 1'b0, 1'b0, 20, 1'b1);
        issue(64'hFFFF_FFFF_FFFF_FFF9, 64'hAAAA_AAAA_0000_0002, 1'b1, 1'b1, 0, 1'b1);
        drain();

        // Flush during CALC cycle 10 discards the operation.
        issue(64'd1000, 64'd3, 1'b0, 1'b0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        chk("flush_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        // Flush in IDLE blocks acceptance even with in_valid high.
        flush = 1'b1; in_valid = 1'b1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_no_accept", 64'(busy), 64'd0);
        repeat (80) @(negedge clk);
        issue(64'd9, 64'd3, 1'b0, 1'b0, 0, 1'b1);
        drain();

        // Reset mid-CALC abandons the operation.
        issue(64'd12345, 64'd11, 1'b1, 1'b0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_quotient", quotient, 64'd0);
        chk("midrst_remainder", remainder, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        issue(64'd100, 64'd7, 1'b0, 1'b0, 0, 1'b1);
        drain();

        for (int i = 0; i < 800; i++) begin
            issue(rnd64(), rnd64(), 1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
